// File: rtl/etapa_salida_if.sv
// Result bus between the last divider stage, the output stage and the downstream reader.
// The slave modport is the output stage; the master modport is the producer/consumer side.
interface etapa_salida_if #(
  parameter int unsigned AnchoDd = 31,
  parameter int unsigned AnchoQ  = 15,
  parameter int unsigned SupDvMn = 16
);
  logic                       goIn;
  logic [AnchoDd:0]           dividendIn;
  logic [AnchoQ:0]            quotientIn;
  logic                       negDivisorIn;
  logic                       negDividendIn;
  logic                       DivisorNoCeroIn;
  logic                       ackIn;
  logic                       validOut;
  logic [AnchoQ:0]            quotientOut;
  logic [AnchoDd-SupDvMn:0]   remainderOut;
  logic                       errOut;
  logic                       fullOut;
  logic                       overrunOut;

  modport master (
    output goIn, dividendIn, quotientIn, negDivisorIn, negDividendIn, DivisorNoCeroIn, ackIn,
    input  validOut, quotientOut, remainderOut, errOut, fullOut, overrunOut
  );

  modport slave (
    input  goIn, dividendIn, quotientIn, negDivisorIn, negDividendIn, DivisorNoCeroIn, ackIn,
    output validOut, quotientOut, remainderOut, errOut, fullOut, overrunOut
  );
endinterface

// File: rtl/etapa_salida.sv
// Final divider stage: sign-corrects quotient/remainder, flags divide-by-zero and queues
// results in a 2-entry FIFO drained by a valid/ack consumer.
module etapa_salida #(
  parameter int unsigned AnchoDv = 15,
  parameter int unsigned AnchoDd = 31,
  parameter int unsigned AnchoQ  = 15,
  parameter int unsigned SupDvMn = 16
) (
  input  logic           clk,
  input  logic           reset,
  etapa_salida_if.slave  bus
);
  localparam int unsigned AnchoR = AnchoDd - SupDvMn + 1;

  // The quotient of this divider is as wide as its divisor.
  if (AnchoQ != AnchoDv) begin : g_bad_width
    $error("etapa_salida: AnchoQ must equal AnchoDv");
  end

  typedef struct packed {
    logic [AnchoQ:0]   q;
    logic [AnchoR-1:0] r;
    logic              err;
  } entry_t;

  // Sign correction.
  logic [AnchoR-1:0] w_rmag;
  logic              w_neg_q;
  entry_t            w_entry;
  logic              w_unused_lo;

  assign w_rmag      = bus.dividendIn[AnchoDd:SupDvMn];
  assign w_neg_q     = bus.negDivisorIn ^ bus.negDividendIn;
  assign w_unused_lo = ^bus.dividendIn[SupDvMn-1:0];

  always_comb begin
    w_entry = '0;
    if (!bus.DivisorNoCeroIn) begin
      w_entry.q   = '1;
      w_entry.r   = '0;
      w_entry.err = 1'b1;
    end else begin
      w_entry.q   = w_neg_q ? (~bus.quotientIn + 1'b1) : bus.quotientIn;
      w_entry.r   = bus.negDividendIn ? (~w_rmag + 1'b1) : w_rmag;
      w_entry.err = 1'b0;
    end
  end

  // Output buffer.
  entry_t     r_mem [2];
  entry_t     r_last;
  logic       r_wptr;
  logic       r_rptr;
  logic [1:0] r_count;
  logic       r_overrun;

  logic       w_valid;
  logic       w_full;
  logic       w_push;
  logic       w_pop;
  entry_t     w_head;

  assign w_valid = (r_count != 2'd0);
  assign w_full  = (r_count == 2'd2);
  assign w_push  = bus.goIn;
  assign w_pop   = bus.ackIn & w_valid;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_mem[0]  <= '0;
      r_mem[1]  <= '0;
      r_last    <= '0;
      r_wptr    <= 1'b0;
      r_rptr    <= 1'b0;
      r_count   <= 2'd0;
      r_overrun <= 1'b0;
    end else begin
      // A push into a full buffer is only accepted when the head leaves in the same cycle.
      if (w_push && (w_pop || !w_full)) begin
        r_mem[r_wptr] <= w_entry;
        r_wptr        <= ~r_wptr;
      end
      if (w_push && !w_pop && w_full) begin
        r_overrun <= 1'b1;
      end
      if (w_pop) begin
        r_last <= r_mem[r_rptr];
        r_rptr <= ~r_rptr;
      end
      if (w_push && !w_pop && !w_full) begin
        r_count <= r_count + 2'd1;
      end else if (w_pop && !w_push) begin
        r_count <= r_count - 2'd1;
      end
    end
  end

  // Empty buffer keeps showing the last entry read (or the reset value).
  always_comb begin
    w_head = r_last;
    if (w_valid) begin
      w_head = r_mem[r_rptr];
    end
  end

  assign bus.validOut     = w_valid;
  assign bus.fullOut      = w_full;
  assign bus.overrunOut   = r_overrun;
  assign bus.quotientOut  = w_head.q;
  assign bus.remainderOut = w_head.r;
  assign bus.errOut       = w_head.err;
endmodule

// File: tb/tb_etapa_salida.sv
// Directed bench for etapa_salida: sign correction, divide-by-zero, FIFO order and overrun.
module tb_etapa_salida;
  logic clk;
  logic reset;
  int   n_cmp;
  int   n_err;

  etapa_salida_if bus ();

  etapa_salida dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one result on the input side (no clock edge).
  task automatic drive(input logic [15:0] q, input logic [15:0] rmag, input logic nd,
                       input logic nv, input logic nz);
    bus.goIn            = 1'b1;
    bus.quotientIn      = q;
    bus.dividendIn      = {rmag, 16'h5a5a};
    bus.negDividendIn   = nd;
    bus.negDivisorIn    = nv;
    bus.DivisorNoCeroIn = nz;
  endtask

  task automatic idle();
    bus.goIn            = 1'b0;
    bus.ackIn           = 1'b0;
    bus.quotientIn      = '0;
    bus.dividendIn      = '0;
    bus.negDividendIn   = 1'b0;
    bus.negDivisorIn    = 1'b0;
    bus.DivisorNoCeroIn = 1'b1;
  endtask

  task automatic send(input logic [15:0] q, input logic [15:0] rmag, input logic nd,
                      input logic nv, input logic nz);
    drive(q, rmag, nd, nv, nz);
    tick();
    idle();
  endtask

  task automatic ack();
    bus.ackIn = 1'b1;
    tick();
    bus.ackIn = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic head(input string tag, input logic [15:0] q, input logic [15:0] r,
                      input logic e);
    check({tag, ".valid"}, 32'(bus.validOut), 32'd1);
    check({tag, ".q"}, 32'(bus.quotientOut), 32'(q));
    check({tag, ".r"}, 32'(bus.remainderOut), 32'(r));
    check({tag, ".err"}, 32'(bus.errOut), 32'(e));
  endtask

  // Push one result, check it at the head, then drain it.
  task automatic one(input string tag, input logic [15:0] qin, input logic [15:0] rmag,
                     input logic nd, input logic nv, input logic nz, input logic [15:0] q,
                     input logic [15:0] r, input logic e);
    send(qin, rmag, nd, nv, nz);
    head(tag, q, r, e);
    ack();
    check({tag, ".empty"}, 32'(bus.validOut), 32'd0);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    idle();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    check("rst.valid", 32'(bus.validOut), 32'd0);
    check("rst.full", 32'(bus.fullOut), 32'd0);
    check("rst.ovr", 32'(bus.overrunOut), 32'd0);
    check("rst.q", 32'(bus.quotientOut), 32'd0);
    check("rst.r", 32'(bus.remainderOut), 32'd0);
    check("rst.err", 32'(bus.errOut), 32'd0);

    // 100/7 with hold while ackIn stays low.
    send(16'd14, 16'd2, 1'b0, 1'b0, 1'b1);
    head("p100d7", 16'd14, 16'd2, 1'b0);
    tick();
    tick();
    head("p100d7.hold", 16'd14, 16'd2, 1'b0);
    ack();
    check("p100d7.empty", 32'(bus.validOut), 32'd0);

    one("n100d7", 16'd14, 16'd2, 1'b1, 1'b0, 1'b1, 16'hfff2, 16'hfffe, 1'b0);
    one("p100dn7", 16'd14, 16'd2, 1'b0, 1'b1, 1'b1, 16'hfff2, 16'h0002, 1'b0);
    one("n100dn7", 16'd14, 16'd2, 1'b1, 1'b1, 1'b1, 16'h000e, 16'hfffe, 1'b0);
    one("min", 16'h8000, 16'h8000, 1'b1, 1'b0, 1'b1, 16'h8000, 16'h8000, 1'b0);
    one("zero", 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b1, 16'h0000, 16'h0000, 1'b0);
    one("div0", 16'h1234, 16'h0042, 1'b1, 1'b1, 1'b0, 16'hffff, 16'h0000, 1'b1);

    // Overrun: A, B stored, C dropped.
    send(16'd1, 16'd10, 1'b0, 1'b0, 1'b1);
    check("ovr.full1", 32'(bus.fullOut), 32'd0);
    send(16'd2, 16'd20, 1'b0, 1'b0, 1'b1);
    check("ovr.full2", 32'(bus.fullOut), 32'd1);
    check("ovr.ovr2", 32'(bus.overrunOut), 32'd0);
    send(16'd3, 16'd30, 1'b0, 1'b0, 1'b1);
    check("ovr.ovr3", 32'(bus.overrunOut), 32'd1);
    check("ovr.full3", 32'(bus.fullOut), 32'd1);
    head("ovr.A", 16'd1, 16'd10, 1'b0);
    ack();
    head("ovr.B", 16'd2, 16'd20, 1'b0);
    check("ovr.fullB", 32'(bus.fullOut), 32'd0);
    ack();
    check("ovr.empty", 32'(bus.validOut), 32'd0);
    check("ovr.sticky", 32'(bus.overrunOut), 32'd1);
    tick();
    check("ovr.sticky2", 32'(bus.overrunOut), 32'd1);

    // Full buffer with push and pop in the same cycle.
    do_reset();
    check("pp.rstovr", 32'(bus.overrunOut), 32'd0);
    send(16'd4, 16'd40, 1'b0, 1'b0, 1'b1);
    send(16'd5, 16'd50, 1'b0, 1'b0, 1'b1);
    drive(16'd6, 16'd60, 1'b0, 1'b0, 1'b1);
    bus.ackIn = 1'b1;
    tick();
    idle();
    check("pp.full", 32'(bus.fullOut), 32'd1);
    check("pp.ovr", 32'(bus.overrunOut), 32'd0);
    head("pp.B", 16'd5, 16'd50, 1'b0);
    ack();
    head("pp.D", 16'd6, 16'd60, 1'b0);
    ack();
    check("pp.empty", 32'(bus.validOut), 32'd0);
    check("pp.ovrend", 32'(bus.overrunOut), 32'd0);

    // Reset mid-stream with goIn asserted.
    send(16'd7, 16'd70, 1'b0, 1'b0, 1'b1);
    send(16'd8, 16'd80, 1'b0, 1'b0, 1'b1);
    send(16'd9, 16'd90, 1'b0, 1'b0, 1'b1);
    check("mr.ovr", 32'(bus.overrunOut), 32'd1);
    drive(16'd11, 16'd11, 1'b0, 1'b0, 1'b1);
    bus.ackIn = 1'b1;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    idle();
    check("mr.valid", 32'(bus.validOut), 32'd0);
    check("mr.full", 32'(bus.fullOut), 32'd0);
    check("mr.ovr0", 32'(bus.overrunOut), 32'd0);
    check("mr.q", 32'(bus.quotientOut), 32'd0);
    tick();
    check("mr.valid2", 32'(bus.validOut), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/etapa_salida.md
Name: etapa_salida

Overview:
- Final stage of the pipelined divider. Sits directly downstream of the stage that restores the upper dividend and performs the last quotient increment.
- Applies sign correction to the unsigned quotient and remainder, and flags divide-by-zero.
- Pushes each finished result into a 2-entry output buffer. A consumer drains the buffer through a valid/ack handshake, so the free-running pipeline (one result per goIn) is decoupled from a slower reader.

Parameters:
- AnchoDv, 15, MSB index of divisor (divisor width = AnchoDv+1)
- AnchoDd, 31, MSB index of dividend/partial-remainder word
- AnchoQ, 15, MSB index of quotient
- SupDvMn, 16, LSB index of the upper half of dividendIn, which holds the remainder

Ports:
- clk  input  1  clock, all state updates on rising edge
- reset  input  1  synchronous reset, active-high
- goIn  input  1  result from previous stage valid this cycle
- dividendIn  input  AnchoDd+1  restored partial-remainder word; remainder magnitude = dividendIn[AnchoDd:SupDvMn]
- quotientIn  input  AnchoQ+1  unsigned quotient magnitude
- negDivisorIn  input  1  original divisor was negative
- negDividendIn  input  1  original dividend was negative
- DivisorNoCeroIn  input  1  1 = divisor non-zero
- ackIn  input  1  consumer takes the head entry this cycle
- validOut  output  1  buffer non-empty; head entry presented
- quotientOut  output  AnchoQ+1  signed quotient of head entry
- remainderOut  output  AnchoDd-SupDvMn+1  signed remainder of head entry
- errOut  output  1  head entry is a divide-by-zero result
- fullOut  output  1  buffer holds 2 entries
- overrunOut  output  1  sticky: a result was dropped because the buffer was full

Behaviour:
- Reset (synchronous, reset=1 at rising edge):
  - count=0, read/write pointers=0.
  - validOut=0, fullOut=0, overrunOut=0.
  - quotientOut, remainderOut and errOut read 0.
  - Reset overrides any simultaneous goIn/ackIn.
  - Reset mid-stream discards buffered entries.
- Sign correction (combinational, before the buffer):
  - negQ = negDivisorIn ^ negDividendIn.
  - Q = negQ ? (~quotientIn + 1) : quotientIn.
  - R = negDividendIn ? (~Rmag + 1) : Rmag, where Rmag = dividendIn[AnchoDd:SupDvMn].
  - Remainder takes the sign of the dividend; quotient truncates toward zero.
  - Negation is modulo 2^width. Magnitude 0x8000 negates to 0x8000 (no saturation). A zero magnitude with a negative flag stays 0.
  - If DivisorNoCeroIn=0: Q = all ones, R = 0, err = 1. Sign flags are ignored. Otherwise err = 0.
- Buffer:
  - 2 entries {Q, R, err}, FIFO order.
  - push = goIn. pop = ackIn & validOut; ackIn while validOut=0 is ignored.
  - Latency: an entry pushed at edge t is visible on the outputs from cycle t+1 (validOut=1 if the buffer was empty).
  - Outputs always reflect the head entry. They hold stable while validOut=1 and ackIn=0.
  - push & !pop & count<2: write the entry, count+1.
  - pop & !push: count-1, head advances.
  - push & pop, any count: write and read in the same cycle; count unchanged; no overrun even when full.
  - push & !pop & count==2: the entry is dropped and overrunOut becomes 1. overrunOut stays 1 until reset. Stored entries are untouched.
- Pointers are 1 bit each and wrap modulo 2.
- validOut = (count!=0); fullOut = (count==2).
- When empty, output data holds the last-read or reset value; consumers must gate on validOut.

Test Plan:
- 100/7: Rmag=2, quotientIn=14, neg flags 0, DivisorNoCeroIn=1, one goIn pulse, ackIn=0 -> next cycle validOut=1, quotientOut=14, remainderOut=2, errOut=0; held until ackIn, then validOut=0.
- Signs:
  - -100/7 (negDividendIn=1) -> Q=0xFFF2, R=0xFFFE.
  - 100/-7 (negDivisorIn=1) -> Q=0xFFF2, R=0x0002.
  - -100/-7 -> Q=0x000E, R=0xFFFE.
- Divide by zero: DivisorNoCeroIn=0, any quotientIn/signs -> quotientOut=0xFFFF, remainderOut=0, errOut=1.
- Overrun:
  - Three consecutive goIn pulses (results A, B, C), ackIn=0 -> fullOut=1 after the 2nd, C dropped, overrunOut=1.
  - Then ack twice -> A then B delivered in order; validOut=0; overrunOut still 1.
- Full with simultaneous push and pop: buffer holds A, B; goIn with D and ackIn same cycle -> A consumed, D stored; next head B then D; overrunOut stays 0.
- Reset mid-stream: two entries buffered and overrunOut=1, reset pulsed with goIn=1 -> validOut=0, fullOut=0, overrunOut=0, nothing stored.
